wb_eth_csr: RTL and testbench

Wishbone B4 classic slave holding the Ethernet receive-path control/status registers.
- Generalises the single MAC/IP/port register set into NUM_FILTERS address-filter slots, each with an enable.
- Adds byte-lane writes, a W1C interrupt status/mask pair and a saturating received-frame counter.
- Sits between the PicoRV Wishbone bus and the rx_ethernet/rx_ipv4/rx_udp chain. All event inputs are already synchronous to wb_clk_i.

---
 rtl/eth_csr_pkg.sv | 42 ++++
 rtl/eth_csr_filter_entry.sv | 59 +++++
 rtl/wb_eth_csr.sv | 167 ++++++++++++++++
 tb/tb_wb_eth_csr.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_csr_pkg.sv
// Shared constants and helpers for the Ethernet RX CSR block.
// Offsets, slot layout and the byte-lane merge helper.
package eth_csr_pkg;

  localparam logic [3:0] OFF_ID         = 4'h0;
  localparam logic [3:0] OFF_IRQ_STATUS = 4'h4;
  localparam logic [3:0] OFF_IRQ_MASK   = 4'h8;
  localparam logic [3:0] OFF_RX_COUNT   = 4'hC;

  localparam logic [1:0] SUB_MAC_LO = 2'd0;
  localparam logic [1:0] SUB_MAC_HI = 2'd1;
  localparam logic [1:0] SUB_IP     = 2'd2;
  localparam logic [1:0] SUB_PORT   = 2'd3;

  localparam logic [31:0] SLOT_BASE   = 32'h10;
  localparam logic [31:0] SLOT_STRIDE = 32'h10;
  localparam int unsigned ENABLE_BIT  = 16;

  typedef enum int {
    IRQ_ETH  = 0,
    IRQ_IPV4 = 1,
    IRQ_UDP  = 2
  } irq_idx_e;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
    logic        en;
  } filter_t;

  function automatic logic [31:0] lane_write(
    input logic [31:0] cur,
    input logic [31:0] nxt,
    input logic [3:0]  sel
  );
    lane_write = cur;
    for (int b = 0; b < 4; b++)
      if (sel[b]) lane_write[8*b +: 8] = nxt[8*b +: 8];
  endfunction

endpackage

// File: rtl/eth_csr_filter_entry.sv
// One address-filter slot: MAC/IP/port/enable with byte-lane writes.
// Read data is a combinational mux over the four slot words.
module eth_csr_filter_entry
  import eth_csr_pkg::*;
#(
  parameter logic [47:0] DEF_MAC = '0,
  parameter logic [31:0] DEF_IP  = '0,
  parameter logic        DEF_EN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  sub,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  output filter_t     slot,
  output logic [31:0] rdata
);

  logic [31:0] nxt;
  logic        unused_bits;

  always_comb begin
    rdata = '0;
    unique case (sub)
      SUB_MAC_LO: rdata = slot.mac[31:0];
      SUB_MAC_HI: rdata[15:0] = slot.mac[47:32];
      SUB_IP:     rdata = slot.ip;
      SUB_PORT: begin
        rdata[15:0]       = slot.port;
        rdata[ENABLE_BIT] = slot.en;
      end
    endcase
  end

  // Merge against the current word so unselected lanes keep their value.
  assign nxt = lane_write(rdata, wdata, sel);
  assign unused_bits = ^nxt[31:17];

  always_ff @(posedge clk) begin
    if (rst) begin
      slot.mac  <= DEF_MAC;
      slot.ip   <= DEF_IP;
      slot.port <= '0;
      slot.en   <= DEF_EN;
    end else if (we) begin
      unique case (sub)
        SUB_MAC_LO: slot.mac[31:0]  <= nxt;
        SUB_MAC_HI: slot.mac[47:32] <= nxt[15:0];
        SUB_IP:     slot.ip         <= nxt;
        SUB_PORT: begin
          slot.port <= nxt[15:0];
          slot.en   <= nxt[ENABLE_BIT];
        end
      endcase
    end
  end

endmodule

// File: rtl/wb_eth_csr.sv
// Wishbone classic CSR slave for the Ethernet RX filter chain.
// Define WB_ERR_EN to answer unmapped accesses with wbs_err_o.
module wb_eth_csr
  import eth_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          NUM_FILTERS = 4,
  parameter int          NUM_IRQ     = 3,
  parameter logic [31:0] ID_VALUE    = 32'h5654_0001,
  parameter logic [47:0] DEF_MAC     = 48'h01005e0000fb,
  parameter logic [31:0] DEF_IP      = 32'he00000fb
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [NUM_IRQ-1:0]       irq_event_i,
  input  logic                     rx_frame_i,
  output logic [48*NUM_FILTERS-1:0] mac_addr_o,
  output logic [32*NUM_FILTERS-1:0] ip_addr_o,
  output logic [16*NUM_FILTERS-1:0] port_o,
  output logic [NUM_FILTERS-1:0]   filter_en_o,
  output logic                     irq_o
`ifdef WB_ERR_EN
  ,
  output logic                     wbs_err_o
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  localparam logic [31:0] WIN =
    32'(SLOT_BASE + SLOT_STRIDE * NUM_FILTERS);
  localparam logic [31:0] IRQ_BITS =
    32'((64'd1 << NUM_IRQ) - 64'd1);

  logic [0:0]  state;
  logic [31:0] sts;
  logic [31:0] msk;
  logic [31:0] rx_count;
  logic [31:0] off;
  logic [31:0] rd;
  logic [31:0] w1c;
  logic [3:0]  wsub;
  logic        access;
  logic        wr;
  logic        mapped;
  logic        glob;
  logic        hit_id;
  logic        hit_sts;
  logic        hit_msk;
  logic        hit_cnt;

  logic [NUM_FILTERS-1:0] hit_slot;
  logic [31:0]            slot_rd [NUM_FILTERS];
  filter_t                slots   [NUM_FILTERS];

  assign access = (state == IDLE) && wbs_stb_i && wbs_cyc_i;
  assign wr     = access && wbs_we_i;

  // Offset wraps for addresses below the base, so one compare covers both ends.
  assign off    = wbs_adr_i - BASE_ADDR;
  assign mapped = off < WIN;
  assign glob   = mapped && (off[31:4] == 28'd0);
  assign wsub   = {off[3:2], 2'b00};

  assign hit_id  = glob && (wsub == OFF_ID);
  assign hit_sts = glob && (wsub == OFF_IRQ_STATUS);
  assign hit_msk = glob && (wsub == OFF_IRQ_MASK);
  assign hit_cnt = glob && (wsub == OFF_RX_COUNT);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FILTERS; gi++) begin : g_slot
      assign hit_slot[gi] = mapped && (off[31:4] == 28'(gi + 1));

      eth_csr_filter_entry #(
        .DEF_MAC (gi == 0 ? DEF_MAC : 48'h0),
        .DEF_IP  (gi == 0 ? DEF_IP : 32'h0),
        .DEF_EN  (gi == 0)
      ) u_entry (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .we    (wr && hit_slot[gi]),
        .sub   (off[3:2]),
        .sel   (wbs_sel_i),
        .wdata (wbs_dat_i),
        .slot  (slots[gi]),
        .rdata (slot_rd[gi])
      );

      assign mac_addr_o[48*gi +: 48] = slots[gi].mac;
      assign ip_addr_o[32*gi +: 32]  = slots[gi].ip;
      assign port_o[16*gi +: 16]     = slots[gi].port;
      assign filter_en_o[gi]         = slots[gi].en;
    end
  endgenerate

  always_comb begin
    rd = '0;
    unique case (1'b1)
      hit_id:  rd = ID_VALUE;
      hit_sts: rd = sts;
      hit_msk: rd = msk;
      hit_cnt: rd = rx_count;
      default:
        for (int i = 0; i < NUM_FILTERS; i++)
          if (hit_slot[i]) rd = slot_rd[i];
    endcase
  end

  assign w1c = (wr && hit_sts) ?
    (lane_write(32'h0, wbs_dat_i, wbs_sel_i) & IRQ_BITS) : 32'h0;

  assign irq_o = |(sts & msk);

  // New events win over a same-cycle W1C clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sts      <= '0;
      msk      <= '0;
      rx_count <= '0;
    end else begin
      sts <= (sts & ~w1c) | (32'(irq_event_i) & IRQ_BITS);
      if (wr && hit_msk)
        msk <= lane_write(msk, wbs_dat_i, wbs_sel_i) & IRQ_BITS;
      if (wr && hit_cnt && (|wbs_sel_i))
        rx_count <= {31'h0, rx_frame_i};
      else if (rx_frame_i && (rx_count != '1))
        rx_count <= rx_count + 32'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
`ifdef WB_ERR_EN
      wbs_err_o <= 1'b0;
`endif
    end else if (state == RESP) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
`ifdef WB_ERR_EN
      wbs_err_o <= 1'b0;
`endif
    end else if (access) begin
      state <= RESP;
`ifdef WB_ERR_EN
      wbs_ack_o <= mapped;
      wbs_err_o <= !mapped;
`else
      wbs_ack_o <= 1'b1;
`endif
      if (!wbs_we_i) wbs_dat_o <= rd;
    end
  end

endmodule

// File: tb/tb_wb_eth_csr.sv
// Randomised self-checking bench for wb_eth_csr.
// Reference model keeps the register file as plain arrays.
module tb_wb_eth_csr;

  localparam int          NF   = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [47:0] DMAC = 48'h01005e0000fb;
  localparam logic [31:0] DIP  = 32'he00000fb;
`ifdef WB_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [2:0]  irq_ev;
  logic        rx;
  logic [48*NF-1:0] mac;
  logic [32*NF-1:0] ip;
  logic [16*NF-1:0] port;
  logic [NF-1:0]    fen;
  logic        irq;
  logic        err_s;

`ifdef WB_ERR_EN
  logic err_o;
  assign err_s = err_o;
`else
  assign err_s = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_eth_csr dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat_i),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_o),
    .irq_event_i (irq_ev),
    .rx_frame_i  (rx),
    .mac_addr_o  (mac),
    .ip_addr_o   (ip),
    .port_o      (port),
    .filter_en_o (fen),
    .irq_o       (irq)
`ifdef WB_ERR_EN
    ,
    .wbs_err_o   (err_o)
`endif
  );

  logic [47:0] m_mac  [NF];
  logic [31:0] m_ip   [NF];
  logic [15:0] m_port [NF];
  logic        m_en   [NF];
  logic [31:0] m_sts;
  logic [31:0] m_msk;
  logic [31:0] m_cnt;
  int passed = 0;
  int total  = 0;

  function automatic void model_reset();
    for (int i = 0; i < NF; i++) begin
      m_mac[i]  = (i == 0) ? DMAC : 48'h0;
      m_ip[i]   = (i == 0) ? DIP : 32'h0;
      m_port[i] = 16'h0;
      m_en[i]   = (i == 0);
    end
    m_sts = 0;
    m_msk = 0;
    m_cnt = 0;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] o;
    int w, sl;
    o = a - BASE;
    if (o >= 32'(16 + 16 * NF)) return 32'h0;
    w = int'(o / 4);
    case (w)
      0: return 32'h5654_0001;
      1: return m_sts;
      2: return m_msk;
      3: return m_cnt;
      default: ;
    endcase
    sl = w / 4 - 1;
    case (w % 4)
      0: return m_mac[sl][31:0];
      1: return {16'h0, m_mac[sl][47:32]};
      2: return m_ip[sl];
      default: return {15'h0, m_en[sl], m_port[sl]};
    endcase
  endfunction

  function automatic void model_write(
    input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] o, t;
    int w, sl;
    o = a - BASE;
    if (o >= 32'(16 + 16 * NF)) return;
    w = int'(o / 4);
    if (w == 1) begin
      t = merge(32'h0, d, s);
      m_sts = m_sts & ~{29'h0, t[2:0]};
      return;
    end
    if (w == 2) begin
      t = merge(m_msk, d, s);
      m_msk = {29'h0, t[2:0]};
      return;
    end
    if (w == 3) begin
      if (s != 4'h0) m_cnt = 0;
      return;
    end
    if (w == 0) return;
    sl = w / 4 - 1;
    t = merge(model_read(a), d, s);
    case (w % 4)
      0: m_mac[sl][31:0] = t;
      1: m_mac[sl][47:32] = t[15:0];
      2: m_ip[sl] = t;
      default: begin
        m_port[sl] = t[15:0];
        m_en[sl] = t[16];
      end
    endcase
  endfunction

  task automatic bus(
    input logic w, input logic [31:0] a, input logic [31:0] d,
    input logic [3:0] s, input logic [2:0] ev, input logic rp,
    output logic [31:0] q, output int lat, output logic was_err);
    @(negedge clk);
    stb = 1; cyc = 1; we = w; adr = a; dat_i = d; sel = s;
    irq_ev = ev; rx = rp;
    lat = -1; was_err = 0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      irq_ev = 0; rx = 0;
      if (ack || err_s) begin
        lat = n; was_err = err_s;
        break;
      end
    end
    q = dat_o;
    stb = 0; cyc = 0; we = 0;
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [2:0] ev, input logic rp, input int n);
    @(negedge clk);
    irq_ev = ev; rx = rp;
    repeat (n) @(negedge clk);
    irq_ev = 0; rx = 0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [8];
    logic [31:0] exps  [8];
    logic [31:0] q;
    int lat;
    logic e;
    addrs = '{32'h3000_0010, 32'h3000_0014, 32'h3000_0018, 32'h3000_001C,
              32'h3000_0000, 32'h3000_0004, 32'h3000_0008, 32'h3000_000C};
    exps  = '{32'h5e0000fb, 32'h00000100, 32'he00000fb, 32'h00010000,
              32'h56540001, 32'h0, 32'h0, 32'h0};
    rst = 1;
    repeat (3) @(negedge clk);
    total++;
    if (ack !== 1'b0 || dat_o !== 32'h0 || irq !== 1'b0)
      $display("FAIL reset_bus ack=%b dat=%h irq=%b req=0/0/0", ack, dat_o, irq);
    else passed++;
    total++;
    if (fen !== 4'b0001 || mac[47:0] !== DMAC || ip[31:0] !== DIP)
      $display("FAIL reset_slot0 en=%b mac=%h ip=%h", fen, mac[47:0], ip[31:0]);
    else passed++;
    rst = 0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      bus(0, addrs[i], 0, 4'hF, 0, 0, q, lat, e);
      total++;
      if (q !== exps[i] || lat !== 1)
        $display("FAIL reset_read a=%h got=%h lat=%0d req=%h lat=1",
                 addrs[i], q, lat, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_slot_write();
    logic [31:0] a, d, q, held;
    logic [3:0] s;
    int lat;
    logic e;
    bus(1, 32'h3000_0020, 32'hAABBCCDD, 4'b0101, 0, 0, q, lat, e);
    model_write(32'h3000_0020, 32'hAABBCCDD, 4'b0101);
    total++;
    if (mac[79:48] !== 32'h00BB00DD || lat !== 1)
      $display("FAIL slot1_mac got=%h lat=%0d req=00bb00dd", mac[79:48], lat);
    else passed++;
    bus(1, 32'h3000_002C, 32'h0001_1F90, 4'hF, 0, 0, q, lat, e);
    model_write(32'h3000_002C, 32'h0001_1F90, 4'hF);
    total++;
    if (port[31:16] !== 16'h1F90 || fen[1] !== 1'b1)
      $display("FAIL slot1_port got=%h en=%b req=1f90/1", port[31:16], fen[1]);
    else passed++;
    for (int it = 0; it < 24; it++) begin
      a = BASE + 32'h10 + 32'($urandom_range(0, 15)) * 4;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      bus(1, a, d, s, 0, 0, q, lat, e);
      model_write(a, d, s);
      bus(0, a, 0, 4'hF, 0, 0, q, lat, e);
      total++;
      if (q !== model_read(a))
        $display("FAIL slot_rand a=%h got=%h req=%h", a, q, model_read(a));
      else passed++;
    end
    held = q;
    bus(1, a, 32'h1234_5678, 4'hF, 0, 0, q, lat, e);
    model_write(a, 32'h1234_5678, 4'hF);
    total++;
    if (dat_o !== held)
      $display("FAIL dat_hold got=%h req=%h", dat_o, held);
    else passed++;
    for (int i = 0; i < NF; i++) begin
      total++;
      if (mac[48*i +: 48] !== m_mac[i] || ip[32*i +: 32] !== m_ip[i] ||
          port[16*i +: 16] !== m_port[i] || fen[i] !== m_en[i])
        $display("FAIL slot_out%0d got=%h/%h/%h/%b req=%h/%h/%h/%b", i,
                 mac[48*i +: 48], ip[32*i +: 32], port[16*i +: 16], fen[i],
                 m_mac[i], m_ip[i], m_port[i], m_en[i]);
      else passed++;
    end
  endtask

  task automatic test_irq();
    logic [31:0] q, d;
    logic [2:0] ev;
    int lat;
    logic e;
    pulse(3'b100, 0, 1);
    m_sts = m_sts | 32'h4;
    bus(0, 32'h3000_0004, 0, 4'hF, 0, 0, q, lat, e);
    total++;
    if (q !== 32'h4 || irq !== 1'b0)
      $display("FAIL irq_set got=%h irq=%b req=4/0", q, irq);
    else passed++;
    bus(1, 32'h3000_0008, 32'h4, 4'hF, 0, 0, q, lat, e);
    model_write(32'h3000_0008, 32'h4, 4'hF);
    total++;
    if (irq !== 1'b1) $display("FAIL irq_mask got=%b req=1", irq);
    else passed++;
    bus(1, 32'h3000_0004, 32'h4, 4'hF, 3'b100, 0, q, lat, e);
    bus(0, 32'h3000_0004, 0, 4'hF, 0, 0, q, lat, e);
    total++;
    if (q !== 32'h4 || irq !== 1'b1)
      $display("FAIL irq_w1c_race got=%h irq=%b req=4/1", q, irq);
    else passed++;
    bus(1, 32'h3000_0004, 32'h4, 4'hF, 0, 0, q, lat, e);
    model_write(32'h3000_0004, 32'h4, 4'hF);
    total++;
    if (irq !== 1'b0) $display("FAIL irq_clear got=%b req=0", irq);
    else passed++;
    for (int it = 0; it < 12; it++) begin
      ev = 3'($urandom_range(0, 7));
      pulse(ev, 0, 1);
      m_sts = m_sts | {29'h0, ev};
      d = $urandom;
      bus(1, 32'h3000_0008, d, 4'h1, 0, 0, q, lat, e);
      model_write(32'h3000_0008, d, 4'h1);
      total++;
      if (irq !== |(m_sts & m_msk))
        $display("FAIL irq_rand got=%b req=%b", irq, |(m_sts & m_msk));
      else passed++;
      d = $urandom;
      bus(1, 32'h3000_0004, d, 4'h1, 0, 0, q, lat, e);
      model_write(32'h3000_0004, d, 4'h1);
      bus(0, 32'h3000_0004, 0, 4'hF, 0, 0, q, lat, e);
      total++;
      if (q !== m_sts || irq !== |(m_sts & m_msk))
        $display("FAIL irq_sts got=%h irq=%b req=%h", q, irq, m_sts);
      else passed++;
    end
  endtask

  task automatic test_rx_count();
    logic [31:0] q;
    int lat, n;
    logic e;
    bus(1, 32'h3000_000C, 0, 4'hF, 0, 0, q, lat, e);
    m_cnt = 0;
    pulse(0, 1, 5);
    m_cnt = m_cnt + 5;
    bus(0, 32'h3000_000C, 0, 4'hF, 0, 0, q, lat, e);
    total++;
    if (q !== m_cnt) $display("FAIL rx_count5 got=%h req=%h", q, m_cnt);
    else passed++;
    bus(1, 32'h3000_000C, 0, 4'h1, 0, 1, q, lat, e);
    m_cnt = 1;
    bus(0, 32'h3000_000C, 0, 4'hF, 0, 0, q, lat, e);
    total++;
    if (q !== m_cnt) $display("FAIL rx_clr_race got=%h req=%h", q, m_cnt);
    else passed++;
    n = $urandom_range(1, 9);
    pulse(0, 1, n);
    m_cnt = m_cnt + 32'(n);
    bus(1, 32'h3000_000C, 0, 4'h0, 0, 0, q, lat, e);
    bus(0, 32'h3000_000C, 0, 4'hF, 0, 0, q, lat, e);
    total++;
    if (q !== m_cnt) $display("FAIL rx_sel0 got=%h req=%h", q, m_cnt);
    else passed++;
    @(negedge clk);
    force dut.rx_count = 32'hFFFF_FFFE;
    #1;
    release dut.rx_count;
    m_cnt = 32'hFFFF_FFFE;
    pulse(0, 1, 3);
    for (int i = 0; i < 3; i++)
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    bus(0, 32'h3000_000C, 0, 4'hF, 0, 0, q, lat, e);
    total++;
    if (q !== m_cnt) $display("FAIL rx_sat got=%h req=%h", q, m_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2;
    logic [3:0] seq;
    int acks;
    d1 = $urandom;
    d2 = $urandom;
    acks = 0;
    seq = 0;
    @(negedge clk);
    stb = 1; cyc = 1; we = 1; sel = 4'hF;
    adr = 32'h3000_0038; dat_i = d1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seq[i] = ack;
      if (ack) acks++;
      if (i == 0) begin
        total++;
        if (ip[95:64] !== d1)
          $display("FAIL b2b_first got=%h req=%h", ip[95:64], d1);
        else passed++;
        dat_i = d2;
      end
    end
    @(negedge clk);
    stb = 0; cyc = 0; we = 0;
    m_ip[2] = d2;
    total++;
    if (acks !== 2 || seq !== 4'b0101)
      $display("FAIL b2b_acks got=%0d seq=%b req=2/0101", acks, seq);
    else passed++;
    total++;
    if (ip[95:64] !== d2)
      $display("FAIL b2b_second got=%h req=%h", ip[95:64], d2);
    else passed++;
    @(negedge clk);
    stb = 1; cyc = 1; we = 1; sel = 4'hF;
    adr = 32'h3000_0028; dat_i = 32'hDEAD_BEEF; rst = 1;
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b0) $display("FAIL rst_req_ack got=%b req=0", ack);
    else passed++;
    @(negedge clk);
    rst = 0; stb = 0; cyc = 0; we = 0;
    model_reset();
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b0 || ip[63:32] !== m_ip[1] || ip[95:64] !== m_ip[2])
      $display("FAIL rst_req_drop ack=%b ip1=%h ip2=%h req=0/%h/%h",
               ack, ip[63:32], ip[95:64], m_ip[1], m_ip[2]);
    else passed++;
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [4];
    logic [31:0] q, a;
    int lat;
    logic e, mp;
    addrs = '{32'h3000_0100, 32'h3000_0050, 32'h2FFF_FFFC, 32'h3000_004C};
    for (int i = 0; i < 4; i++) begin
      a = addrs[i];
      mp = (a - BASE) < 32'(16 + 16 * NF);
      bus(0, 32'h3000_0000, 0, 4'hF, 0, 0, q, lat, e);
      bus(1, a, $urandom, 4'hF, 0, 0, q, lat, e);
      bus(0, a, 0, 4'hF, 0, 0, q, lat, e);
      if (mp) begin
        total++;
        if (lat !== 1 || e !== 1'b0)
          $display("FAIL last_slot a=%h lat=%0d err=%b req=1/0", a, lat, e);
        else passed++;
      end else begin
        total++;
        if (lat !== 1 || q !== 32'h0 || e !== ERR_EXP)
          $display("FAIL unmapped a=%h lat=%0d dat=%h err=%b req=1/0/%b",
                   a, lat, q, e, ERR_EXP);
        else passed++;
      end
    end
    total++;
    if (mac !== {m_mac[3], m_mac[2], m_mac[1], m_mac[0]} ||
        ip[95:0] !== {m_ip[2], m_ip[1], m_ip[0]})
      $display("FAIL unmapped_wr mac=%h ip=%h", mac, ip);
    else passed++;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1; stb = 0; cyc = 0; we = 0; sel = 0;
    adr = 0; dat_i = 0; irq_ev = 0; rx = 0;
    model_reset();
    test_reset();
    test_slot_write();
    test_irq();
    test_rx_count();
    test_back_to_back();
    test_unmapped();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
